// File: rtl/mitchell_dot_acc.sv
// mitchell_dot_acc: sums signed product groups into a one-entry result register; define MITCHELL_ACC_SAT_EN to saturate instead of wrap
module mitchell_dot_acc #(
  parameter int PROD_W    = 17,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 64,
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PROD_W-1:0]       prod_i,
  input  logic                    prod_valid_i,
  input  logic                    prod_last_i,
  output logic                    prod_ready_o,
  output logic signed [ACC_W-1:0] acc_o,
  output logic [CNT_W-1:0]        acc_cnt_o,
  output logic                    acc_trunc_o,
  output logic                    acc_ovf_o,
  output logic                    acc_valid_o,
  input  logic                    acc_ready_i
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state_q, state_d;
  logic signed [ACC_W-1:0] sum_q, sext, raw, next_sum;
  logic [CNT_W-1:0] cnt_q, next_cnt;
  logic accept, at_max, close, consume;
  assign acc_valid_o  = state_q == HOLD;
  assign prod_ready_o = ~acc_valid_o | acc_ready_i;
  assign accept       = prod_valid_i & prod_ready_o;
  assign consume      = acc_valid_o & acc_ready_i;
  assign at_max       = cnt_q == CNT_W'(MAX_TERMS - 1);
  assign close        = accept & (prod_last_i | at_max);
  assign sext         = {{(ACC_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
  assign raw          = sum_q + sext;
  assign next_cnt     = cnt_q + CNT_W'(1);
  always_comb begin
    state_d = close ? HOLD : consume ? ACCUM : state_q;
  end
`ifdef MITCHELL_ACC_SAT_EN
  logic ovf, sticky_q;
  assign ovf      = (sum_q[ACC_W-1] == sext[ACC_W-1]) & (raw[ACC_W-1] != sum_q[ACC_W-1]);
  assign next_sum = ~ovf ? raw : sext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sticky_q  <= 1'b0;
      acc_ovf_o <= 1'b0;
    end else begin
      if (accept) sticky_q <= ~close & (sticky_q | ovf);
      if (close) acc_ovf_o <= sticky_q | ovf;
    end
  end
`else
  assign next_sum  = raw;
  assign acc_ovf_o = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      acc_o       <= '0;
      acc_cnt_o   <= '0;
      acc_trunc_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sum_q <= close ? '0 : next_sum;
        cnt_q <= close ? '0 : next_cnt;
      end
      if (close) begin
        acc_o       <= next_sum;
        acc_cnt_o   <= next_cnt;
        acc_trunc_o <= ~prod_last_i & at_max;
      end
    end
  end
endmodule

// File: tb/tb_mitchell_dot_acc.sv
// tb_mitchell_dot_acc: directed checks on a default instance and a narrow ACC_W=18, MAX_TERMS=4 instance
module tb_mitchell_dot_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16:0] prod [2];
  logic vld [2];
  logic last [2];
  logic rdy [2];
  logic prdy [2];
  logic [23:0] acc0;
  logic [5:0] cnt0;
  logic [17:0] acc1;
  logic [2:0] cnt1;
  logic trunc [2];
  logic ovf [2];
  logic aval [2];
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mitchell_dot_acc u_d0 (
    .clk_i(clk), .rst_ni(rst_n), .prod_i(prod[0]), .prod_valid_i(vld[0]),
    .prod_last_i(last[0]), .prod_ready_o(prdy[0]), .acc_o(acc0), .acc_cnt_o(cnt0),
    .acc_trunc_o(trunc[0]), .acc_ovf_o(ovf[0]), .acc_valid_o(aval[0]), .acc_ready_i(rdy[0])
  );
  mitchell_dot_acc #(.ACC_W(18), .MAX_TERMS(4)) u_d1 (
    .clk_i(clk), .rst_ni(rst_n), .prod_i(prod[1]), .prod_valid_i(vld[1]),
    .prod_last_i(last[1]), .prod_ready_o(prdy[1]), .acc_o(acc1), .acc_cnt_o(cnt1),
    .acc_trunc_o(trunc[1]), .acc_ovf_o(ovf[1]), .acc_valid_o(aval[1]), .acc_ready_i(rdy[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input int d, input logic [16:0] p, input logic l);
    vld[d] = 1'b1;
    prod[d] = p;
    last[d] = l;
    tick();
    vld[d] = 1'b0;
    last[d] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      prod[i] = 17'd123;
      vld[i] = 1'b1;
      last[i] = 1'b1;
      rdy[i] = 1'b1;
    end
    tick();
    tick();
    check("rst_valid", 32'(aval[0]), 0);
    check("rst_acc", 32'(acc0), 0);
    check("rst_cnt", 32'(cnt0), 0);
    check("rst_valid1", 32'(aval[1]), 0);
    for (int i = 0; i < 2; i++) vld[i] = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_prdy", 32'(prdy[0]), 1);
    tick();
    check("rst_noretain", 32'(aval[0]), 0);
    beat(0, 17'd7, 1'b1);
    check("single_acc", 32'(acc0), 7);
    check("single_cnt", 32'(cnt0), 1);
    tick();
    beat(0, 17'd100, 1'b0);
    beat(0, 17'h1FFE2, 1'b0);
    check("basic_midvalid", 32'(aval[0]), 0);
    beat(0, 17'd7, 1'b1);
    check("basic_valid", 32'(aval[0]), 1);
    check("basic_acc", 32'(acc0), 77);
    check("basic_cnt", 32'(cnt0), 3);
    check("basic_trunc", 32'(trunc[0]), 0);
    check("basic_ovf", 32'(ovf[0]), 0);
    tick();
    check("basic_pulse", 32'(aval[0]), 0);
    rdy[0] = 1'b0;
    beat(0, 17'd5, 1'b1);
    check("bp_acc", 32'(acc0), 5);
    check("bp_valid", 32'(aval[0]), 1);
    vld[0] = 1'b1;
    prod[0] = 17'd9;
    last[0] = 1'b1;
    #1;
    check("bp_prdy_low", 32'(prdy[0]), 0);
    tick();
    tick();
    check("bp_hold_acc", 32'(acc0), 5);
    check("bp_hold_cnt", 32'(cnt0), 1);
    check("bp_hold_prdy", 32'(prdy[0]), 0);
    rdy[0] = 1'b1;
    #1;
    check("bp_prdy_high", 32'(prdy[0]), 1);
    tick();
    vld[0] = 1'b0;
    last[0] = 1'b0;
    check("bp_nobubble_valid", 32'(aval[0]), 1);
    check("bp_nobubble_acc", 32'(acc0), 9);
    tick();
    check("bp_drained", 32'(aval[0]), 0);
    beat(0, 17'h10000, 1'b0);
    beat(0, 17'h10000, 1'b1);
    check("sext_acc", 32'(acc0), 32'h00FE0000);
    check("sext_cnt", 32'(cnt0), 2);
    tick();
    beat(1, 17'd65535, 1'b0);
    beat(1, 17'd65535, 1'b0);
    beat(1, 17'd65535, 1'b1);
    check("ovf_cnt", 32'(cnt1), 3);
`ifdef MITCHELL_ACC_SAT_EN
    check("ovf_acc", 32'(acc1), 131071);
    check("ovf_flag", 32'(ovf[1]), 1);
`else
    check("ovf_acc", 32'(acc1), 32'h0002FFFD);
    check("ovf_flag", 32'(ovf[1]), 0);
`endif
    tick();
    beat(1, 17'd1, 1'b0);
    beat(1, 17'd2, 1'b0);
    beat(1, 17'd3, 1'b0);
    check("force_early", 32'(aval[1]), 0);
    beat(1, 17'd4, 1'b0);
    check("force_valid", 32'(aval[1]), 1);
    check("force_acc", 32'(acc1), 10);
    check("force_cnt", 32'(cnt1), 4);
    check("force_trunc", 32'(trunc[1]), 1);
    check("force_ovf", 32'(ovf[1]), 0);
    beat(1, 17'd6, 1'b1);
    check("after_acc", 32'(acc1), 6);
    check("after_cnt", 32'(cnt1), 1);
    check("after_trunc", 32'(trunc[1]), 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
